// File: rtl/udp_cmd_sched_if.sv
// Command-word input and frame request/ack/done handshake between the UDP
// receive path, the channel scheduler and the shared UDP/IP send engine.
interface udp_cmd_sched_if #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic              cmd_valid;
  logic [31:0]       cmd_word;
  logic              tx_req;
  logic [CH_W-1:0]   tx_ch;
  logic [15:0]       tx_len;
  logic              tx_ack;
  logic              tx_done;
  logic [NUM_CH-1:0] ch_active;
  logic              busy;
  logic              cmd_ok;
  logic [7:0]        cmd_err_cnt;
  logic              timeout;

  // master: the scheduler; slave: command source plus send engine
  modport master (
    input  cmd_valid, cmd_word, tx_ack, tx_done,
    output tx_req, tx_ch, tx_len, ch_active, busy, cmd_ok, cmd_err_cnt, timeout
  );

  modport slave (
    output cmd_valid, cmd_word, tx_ack, tx_done,
    input  tx_req, tx_ch, tx_len, ch_active, busy, cmd_ok, cmd_err_cnt, timeout
  );
endinterface

// File: rtl/udp_cmd_sched.sv
// Multi-channel UDP send scheduler: decodes command words into per-channel
// modes and round-robins frame requests onto one shared send engine.
module udp_cmd_sched #(
  parameter int          NUM_CH  = 4,
  parameter logic [15:0] DEF_LEN = 16'd256,
  parameter logic [15:0] MAX_LEN = 16'd1472,
  parameter int          IFG_CYC = 12,
  parameter logic [23:0] TO_CYC  = 24'd1000000
) (
  input logic             clk,
  input logic             reset_n,
  udp_cmd_sched_if.master bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [23:0] IFG_LAST = (IFG_CYC > 0) ? 24'(IFG_CYC - 1) : 24'd0;
  localparam logic [7:0] OP_STOP   = 8'h30;
  localparam logic [7:0] OP_SINGLE = 8'h31;
  localparam logic [7:0] OP_STREAM = 8'h32;
  localparam logic [7:0] OP_SETLEN = 8'h33;

  typedef enum logic [1:0] {M_OFF, M_SINGLE, M_STREAM} mode_t;
  typedef enum logic [2:0] {S_IDLE, S_ARB, S_REQ, S_XFER, S_GAP} state_t;

  state_t            state_reg, state_next;
  logic [23:0]       cnt_reg;
  logic [CH_W-1:0]   rr_reg;
  logic [CH_W-1:0]   tx_ch_reg;
  logic [15:0]       tx_len_reg;
  logic              cmd_ok_reg;
  logic [7:0]        err_cnt_reg;
  logic              timeout_reg;
  logic [NUM_CH-1:0] active_vec;
  logic [NUM_CH-1:0][15:0] len_vec;

  // Command decode
  logic [7:0]  op;
  logic [7:0]  cmd_ch;
  logic [15:0] arg;
  logic        op_known, ch_all, ch_ok, cmd_acc, cmd_rej;
  logic [15:0] arg_len;

  assign op       = bus.cmd_word[31:24];
  assign cmd_ch   = bus.cmd_word[23:16];
  assign arg      = bus.cmd_word[15:0];
  assign op_known = (op == OP_STOP) || (op == OP_SINGLE) || (op == OP_STREAM) || (op == OP_SETLEN);
  assign ch_all   = (op == OP_STOP) && (cmd_ch == 8'hFF);
  assign ch_ok    = (int'(cmd_ch) < NUM_CH);
  assign cmd_acc  = bus.cmd_valid && op_known && (ch_ok || ch_all);
  assign cmd_rej  = bus.cmd_valid && !cmd_acc;
  assign arg_len  = (arg == 16'd0) ? DEF_LEN : ((arg > MAX_LEN) ? MAX_LEN : arg);

  // Frame completion includes ack+done arriving together while still in REQ
  logic frame_done, progress, wd_fire;
  assign frame_done = bus.tx_done && ((state_reg == S_XFER) || ((state_reg == S_REQ) && bus.tx_ack));
  assign progress   = (state_reg == S_REQ) ? bus.tx_ack : bus.tx_done;
  assign wd_fire    = ((state_reg == S_REQ) || (state_reg == S_XFER)) &&
                      (cnt_reg == TO_CYC - 24'd1) && !progress;

  // Round-robin: the lowest offset from rr_reg wins, so scan offsets downwards
  logic            grant_found;
  logic [CH_W-1:0] grant_ch;
  int              idx;
  always_comb begin
    grant_found = 1'b0;
    grant_ch    = '0;
    idx         = 0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = (int'(rr_reg) + k) % NUM_CH;
      if (active_vec[idx]) begin
        grant_found = 1'b1;
        grant_ch    = CH_W'(idx);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (|active_vec) state_next = S_ARB;
      S_ARB:  state_next = grant_found ? S_REQ : S_IDLE;
      S_REQ: begin
        if (bus.tx_ack)   state_next = bus.tx_done ? S_GAP : S_XFER;
        else if (wd_fire) state_next = S_GAP;
      end
      S_XFER: if (bus.tx_done || wd_fire) state_next = S_GAP;
      S_GAP:  if (cnt_reg == IFG_LAST) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      rr_reg      <= '0;
      tx_ch_reg   <= '0;
      tx_len_reg  <= '0;
      cmd_ok_reg  <= 1'b0;
      err_cnt_reg <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      // One counter serves both the watchdog and the gap; any state change restarts it
      if (state_next != state_reg)  cnt_reg <= '0;
      else if (state_reg != S_IDLE) cnt_reg <= cnt_reg + 24'd1;
      if (state_reg == S_ARB && grant_found) begin
        tx_ch_reg  <= grant_ch;
        tx_len_reg <= len_vec[grant_ch];
        rr_reg     <= (int'(grant_ch) == NUM_CH - 1) ? '0 : grant_ch + CH_W'(1);
      end
      cmd_ok_reg  <= cmd_acc;
      timeout_reg <= wd_fire;
      if (cmd_rej && err_cnt_reg != 8'hFF) err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      mode_t       mode_reg;
      logic [15:0] len_reg;
      logic [15:0] burst_reg;
      logic        cmd_hit, is_cur;

      assign cmd_hit = cmd_acc && (ch_all || (int'(cmd_ch) == gi));
      assign is_cur  = (int'(tx_ch_reg) == gi);

      // A command in the same cycle as tx_done overrides the completion bookkeeping
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          mode_reg  <= M_OFF;
          len_reg   <= DEF_LEN;
          burst_reg <= '0;
        end else if (cmd_hit) begin
          case (op)
            OP_STOP:   mode_reg <= M_OFF;
            OP_SINGLE: begin
              mode_reg <= M_SINGLE;
              len_reg  <= arg_len;
            end
            OP_STREAM: begin
              mode_reg  <= M_STREAM;
              burst_reg <= arg;
            end
            OP_SETLEN: len_reg <= arg_len;
            default:   ;
          endcase
        end else if (is_cur && frame_done) begin
          if (mode_reg == M_SINGLE) begin
            mode_reg <= M_OFF;
          end else if (mode_reg == M_STREAM && burst_reg != 16'd0) begin
            burst_reg <= burst_reg - 16'd1;
            if (burst_reg == 16'd1) mode_reg <= M_OFF;
          end
        end else if (is_cur && wd_fire && mode_reg == M_SINGLE) begin
          mode_reg <= M_OFF;
        end
      end

      assign active_vec[gi] = (mode_reg != M_OFF);
      assign len_vec[gi]    = len_reg;
    end
  endgenerate

  assign bus.tx_req      = (state_reg == S_REQ);
  assign bus.tx_ch       = tx_ch_reg;
  assign bus.tx_len      = tx_len_reg;
  assign bus.ch_active   = active_vec;
  assign bus.busy        = (state_reg != S_IDLE);
  assign bus.cmd_ok      = cmd_ok_reg;
  assign bus.cmd_err_cnt = err_cnt_reg;
  assign bus.timeout     = timeout_reg;
endmodule

// File: tb/tb_udp_cmd_sched.sv
// Directed bench for udp_cmd_sched: commands, round-robin grants, rejects,
// watchdog, STOP during a frame, length clamp and mid-frame reset.
module tb_udp_cmd_sched;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  udp_cmd_sched_if #(.NUM_CH(4)) bus ();

  udp_cmd_sched #(
    .NUM_CH (4),
    .DEF_LEN(16'd256),
    .MAX_LEN(16'd1472),
    .IFG_CYC(12),
    .TO_CYC (24'd100)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
      $display("check %s obs=%0h exp=%0h", tag, obs, exp);
    end else begin
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_word  = '0;
    bus.tx_ack    = 1'b0;
    bus.tx_done   = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [7:0] ch, input logic [15:0] arg,
                          output logic ok);
    bus.cmd_word  = {op, ch, arg};
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    ok            = bus.cmd_ok;
    bus.cmd_valid = 1'b0;
    bus.cmd_word  = '0;
  endtask

  task automatic wait_req(output logic got);
    int w;
    w = 0;
    while (!bus.tx_req && w < 200) begin
      @(negedge clk);
      w++;
    end
    got = bus.tx_req;
  endtask

  // Send-engine model: ack one cycle, finish the frame two cycles later
  task automatic serve(output logic [3:0] ch, output logic [15:0] len, output logic got);
    wait_req(got);
    ch  = '0;
    len = '0;
    if (got) begin
      ch  = 4'(bus.tx_ch);
      len = bus.tx_len;
      bus.tx_ack = 1'b1;
      @(negedge clk);
      bus.tx_ack = 1'b0;
      repeat (2) @(negedge clk);
      bus.tx_done = 1'b1;
      @(negedge clk);
      bus.tx_done = 1'b0;
    end
  endtask

  task automatic count_req(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.tx_req) n++;
    end
  endtask

  initial begin
    logic        ok, got;
    logic [3:0]  ch;
    logic [15:0] len;
    int          n, g, w;
    logic [3:0]  exp_grant [5];
    exp_grant = '{4'd0, 4'd2, 4'd0, 4'd2, 4'd0};

    // Reset state, sampled while reset is still asserted
    reset_n       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_word  = '0;
    bus.tx_ack    = 1'b0;
    bus.tx_done   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_req", bus.tx_req, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_ch_active", bus.ch_active, 0);
    check("rst_err_cnt", bus.cmd_err_cnt, 0);
    check("rst_tx_len", bus.tx_len, 0);
    check("rst_timeout", bus.timeout, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // SINGLE ch1 len 0x40: one frame then idle
    send_cmd(8'h31, 8'd1, 16'h0040, ok);
    check("a_cmd_ok", ok, 1);
    check("a_ch_active", bus.ch_active, 4'b0010);
    serve(ch, len, got);
    check("a_req_seen", got, 1);
    check("a_tx_ch", ch, 1);
    check("a_tx_len", len, 64);
    check("a_ch_active_off", bus.ch_active, 0);
    count_req(40, n);
    check("a_no_more_req", n, 0);
    check("a_busy_idle", bus.busy, 0);

    // Counted streams on ch0 (3) and ch2 (2) interleave round-robin
    do_reset();
    send_cmd(8'h32, 8'd0, 16'd3, ok);
    check("b_cmd0_ok", ok, 1);
    send_cmd(8'h32, 8'd2, 16'd2, ok);
    check("b_cmd2_ok", ok, 1);
    for (int i = 0; i < 5; i++) begin
      serve(ch, len, got);
      check($sformatf("b_req%0d_seen", i), got, 1);
      check($sformatf("b_grant%0d_ch", i), ch, exp_grant[i]);
      check($sformatf("b_grant%0d_len", i), len, 256);
    end
    check("b_ch_active_off", bus.ch_active, 0);
    count_req(40, n);
    check("b_no_sixth_req", n, 0);

    // Rejected commands count and saturate
    send_cmd(8'h55, 8'd0, 16'd0, ok);
    check("c_badop_no_ok", ok, 0);
    send_cmd(8'h31, 8'd7, 16'd16, ok);
    check("c_badch_no_ok", ok, 0);
    check("c_err_cnt2", bus.cmd_err_cnt, 2);
    count_req(20, n);
    check("c_no_req", n, 0);
    check("c_ch_active", bus.ch_active, 0);
    bus.cmd_word  = {8'h31, 8'hFF, 16'd1};
    bus.cmd_valid = 1'b1;
    repeat (298) @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("c_err_sat", bus.cmd_err_cnt, 255);

    // Continuous stream on ch3, ack withheld: watchdog fires after 100 clocks
    do_reset();
    send_cmd(8'h32, 8'd3, 16'd0, ok);
    check("d_cmd_ok", ok, 1);
    wait_req(got);
    check("d_req_seen", got, 1);
    n = 1;
    w = 0;
    while (!bus.timeout && w < 300) begin
      @(negedge clk);
      w++;
      if (bus.tx_req) n++;
    end
    check("d_timeout_seen", bus.timeout, 1);
    check("d_req_cycles", n, 100);
    check("d_req_low", bus.tx_req, 0);
    check("d_ch_active_kept", bus.ch_active, 4'b1000);
    @(negedge clk);
    check("d_timeout_pulse", bus.timeout, 0);
    g = 1;
    while (!bus.tx_req && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("d_rereq_ch", bus.tx_ch, 3);
    check("d_rereq_after_gap", (g >= 12 && g <= 16), 1);

    // STOP all during XFER of ch2: frame completes, nothing further
    do_reset();
    send_cmd(8'h32, 8'd2, 16'd0, ok);
    wait_req(got);
    check("e_req_seen", got, 1);
    check("e_tx_ch", bus.tx_ch, 2);
    bus.tx_ack = 1'b1;
    @(negedge clk);
    bus.tx_ack = 1'b0;
    check("e_req_dropped", bus.tx_req, 0);
    send_cmd(8'h30, 8'hFF, 16'd0, ok);
    check("e_stop_ok", ok, 1);
    check("e_ch_active_off", bus.ch_active, 0);
    check("e_busy_xfer", bus.busy, 1);
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
    count_req(40, n);
    check("e_no_req", n, 0);
    check("e_busy_idle", bus.busy, 0);

    // SETLEN clamp, zero-length default, reset during REQ
    do_reset();
    send_cmd(8'h33, 8'd1, 16'h2000, ok);
    check("f_setlen_ok", ok, 1);
    check("f_setlen_mode", bus.ch_active, 0);
    send_cmd(8'h31, 8'd2, 16'd0, ok);
    serve(ch, len, got);
    check("f_single0_ch", ch, 2);
    check("f_single0_len", len, 256);
    send_cmd(8'h32, 8'd1, 16'd1, ok);
    serve(ch, len, got);
    check("f_clamp_ch", ch, 1);
    check("f_clamp_len", len, 1472);
    send_cmd(8'h32, 8'd1, 16'd0, ok);
    wait_req(got);
    check("f_req_seen", got, 1);
    reset_n = 1'b0;
    @(negedge clk);
    check("f_rst_tx_req", bus.tx_req, 0);
    check("f_rst_busy", bus.busy, 0);
    check("f_rst_ch_active", bus.ch_active, 0);
    check("f_rst_tx_ch", bus.tx_ch, 0);
    check("f_rst_tx_len", bus.tx_len, 0);
    reset_n = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
